// File: rtl/wb_narbiter.sv
// N-master to one-slave Wishbone pipelined arbiter: round-robin or fixed-priority grant, outstanding tracking, bus-hang abort.
// Latency: o_cyc follows a request by 1 cycle; backpressure: owner stalled by slave stall or full counter, all others always stalled.
module wb_narbiter #(
    parameter int NM               = 4,
    parameter int DW               = 32,
    parameter int AW               = 19,
    parameter int OPT_RR           = 1,
    parameter int LGOUT            = 5,
    parameter int TIMEOUT          = 1024,
    parameter int OPT_ZERO_ON_IDLE = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NM-1:0]        i_cyc,
    input  logic [NM-1:0]        i_stb,
    input  logic [NM-1:0]        i_we,
    input  logic [NM*AW-1:0]     i_adr,
    input  logic [NM*DW-1:0]     i_dat,
    input  logic [NM*DW/8-1:0]   i_sel,
    output logic [NM-1:0]        o_ack,
    output logic [NM-1:0]        o_stall,
    output logic [NM-1:0]        o_err,
    output logic                 o_cyc,
    output logic                 o_stb,
    output logic                 o_we,
    output logic [AW-1:0]        o_adr,
    output logic [DW-1:0]        o_dat,
    output logic [DW/8-1:0]      o_sel,
    input  logic                 i_ack,
    input  logic                 i_stall,
    input  logic                 i_err,
    output logic [NM-1:0]        o_grant
);
    localparam int IW = (NM > 1) ? $clog2(NM) : 1;
    localparam int SW = DW / 8;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [LGOUT-1:0] OUT_MAX = '1;

    typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

    state_t           state, state_nxt;
    logic [IW-1:0]    owner, owner_nxt, last_owner, last_nxt, winner;
    logic [LGOUT-1:0] outstanding, outstanding_nxt;
    logic [TW-1:0]    tcnt, tcnt_nxt;
    logic             own_cyc, own_stb, full, accept, expire;
    int               idx;

    assign own_cyc = i_cyc[owner];
    assign own_stb = i_stb[owner];
    assign full    = (outstanding == OUT_MAX);
    assign accept  = (state == BUSY) && own_cyc && own_stb && !i_stall && !full;
    // An ack on the expiry cycle keeps the bus alive, so it suppresses the abort.
    assign expire  = (TIMEOUT > 0) && (state == BUSY) && own_cyc && (outstanding != '0)
                     && !i_ack && !i_err && (tcnt == TW'(TIMEOUT - 1));

    // Reverse scan: the last hit is the candidate nearest the search start.
    always_comb begin
        winner = '0;
        idx    = 0;
        for (int i = NM - 1; i >= 0; i--) begin
            if (OPT_RR != 0) idx = (int'(last_owner) + 1 + i) % NM;
            else             idx = i;
            if (i_cyc[idx]) winner = IW'(idx);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            owner       <= '0;
            last_owner  <= IW'(NM - 1);
            outstanding <= '0;
            tcnt        <= '0;
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            last_owner  <= last_nxt;
            outstanding <= outstanding_nxt;
            tcnt        <= tcnt_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        owner_nxt       = owner;
        last_nxt        = last_owner;
        outstanding_nxt = outstanding;
        tcnt_nxt        = '0;
        case (state)
            IDLE: begin
                if (|i_cyc) begin
                    owner_nxt = winner;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (!own_cyc) begin
                    state_nxt       = IDLE;
                    last_nxt        = owner;
                    outstanding_nxt = '0;
                end else if (expire) begin
                    state_nxt       = ABORT;
                    outstanding_nxt = '0;
                end else begin
                    if (i_err)
                        outstanding_nxt = '0;
                    else if (accept && !i_ack)
                        outstanding_nxt = outstanding + 1'b1;
                    else if (!accept && i_ack && outstanding != '0)
                        outstanding_nxt = outstanding - 1'b1;
                    if (TIMEOUT > 0 && !i_ack && !i_err && outstanding != '0)
                        tcnt_nxt = tcnt + 1'b1;
                end
            end
            ABORT: begin
                if (!own_cyc) begin
                    state_nxt = IDLE;
                    last_nxt  = owner;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_cyc   = (state == BUSY) && own_cyc && !expire;
        o_stb   = (state == BUSY) && own_stb && !expire;
        o_we    = i_we[owner];
        o_adr   = i_adr[int'(owner)*AW +: AW];
        o_dat   = i_dat[int'(owner)*DW +: DW];
        o_sel   = i_sel[int'(owner)*SW +: SW];
        o_stall = '1;
        o_ack   = '0;
        o_err   = '0;
        o_grant = '0;
        if (state == BUSY) begin
            o_stall[owner] = expire || i_stall || full;
            o_ack[owner]   = i_ack;
            o_err[owner]   = i_err || expire;
        end
        if (state != IDLE) o_grant[owner] = 1'b1;
        if (OPT_ZERO_ON_IDLE != 0 && !o_cyc) begin
            o_stb = 1'b0;
            o_we  = 1'b0;
            o_adr = '0;
            o_dat = '0;
            o_sel = '0;
        end
    end
endmodule
